vrf_rd_seq: RTL and testbench
=============================

Name: vrf_rd_seq

Overview:
- Read sequencer that sits directly upstream of one port of the byte-write true-dual-port vector register file RAM and consumes its read data.
- Accepts a burst request (base word address, beat count) and issues consecutive RAM reads.
- Absorbs the RAM's 1-cycle registered read latency.
- Delivers the words in order on a valid/ready stream with last-beat marking and full-throughput backpressure.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 64, RAM word width (NUM_COL*COL_WIDTH of the RAM).
- LEN_WIDTH, 3, burst-length field width; a burst is req_len+1 beats, so 1..2^LEN_WIDTH.

Ports:
- clk  in  1  single clock for the block and the RAM port it drives.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  burst request accepted when high together with req_valid.
- req_addr  in  ADDR_WIDTH  first word address of the burst.
- req_len  in  LEN_WIDTH  beats minus one.
- ram_en  out  1  RAM port enable (read only; the RAM's write-enable is tied 0 externally).
- ram_addr  out  ADDR_WIDTH  RAM port address.
- ram_dout  in  DATA_WIDTH  RAM registered read data, valid the cycle after ram_en.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_WIDTH  output beat data.
- out_last  out  1  marks the final beat of a burst.
- busy  out  1  high while a burst is issuing, a read is in flight, or the buffer is non-empty.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous, active-low.
  - While rst_n=0: state=IDLE, idx=0, remaining=0, inflight=0, FIFO count=0.
  - Resulting outputs during reset: ram_en=0, out_valid=0, out_last=0, busy=0, req_ready=1.
  - out_data and ram_addr are don't-care while their valid/enable is low.
  - Reset mid-burst drops all state. Data returning on ram_dout the cycle after reset releases is ignored, because inflight=0.
- FSM:
  - IDLE: req_ready=1. On req_valid&req_ready, latch base=req_addr, set remaining=req_len, idx=0, and go to BUSY.
  - BUSY: req_ready=0. Each cycle with credit: ram_en=1, ram_addr=base+idx (ADDR_WIDTH wrap, no carry out), idx++, remaining-- after the issue.
  - When the beat issued has remaining==0, tag it last and return to IDLE in the next cycle.
  - A new request may be accepted on that IDLE cycle while earlier beats are still buffered; ordering is preserved.
- Credit:
  - Buffer is a 2-entry FIFO of {data, last}.
  - pop = out_valid & out_ready.
  - Issue allowed iff count + inflight - pop < 2.
  - ram_en therefore depends combinationally on out_ready. This is required so that with out_ready held high the stream sustains 1 beat/cycle.
  - With out_ready=0 at most 2 reads are outstanding or buffered, and ram_en stays 0 after that.
- Return path:
  - inflight and inflight_last are registered from the issue cycle.
  - On the next cycle ram_dout is pushed into the FIFO with its last tag.
  - Push and pop in the same cycle leave count unchanged.
  - Push when full cannot occur by construction; the bench asserts this.
- Output:
  - out_valid = count!=0; out_data/out_last = FIFO head.
  - Once out_valid is high, out_data/out_last are held stable until pop.
- Latency: request accept at cycle T → first ram_en at T+1 → first out_valid at T+3 (RAM registers the read at T+2, FIFO pushes at T+2, head visible from T+3).
- Boundaries:
  - req_len=0 gives a single beat with out_last=1.
  - req_len=2^LEN_WIDTH-1 gives 8 beats.
  - base+idx crossing 2^ADDR_WIDTH-1 wraps to 0.
  - req_valid while BUSY is not accepted and req_addr is not sampled.
- busy = (state==BUSY) | inflight | (count!=0).

Test Plan:
- Reset then req_addr=0x010, req_len=3, out_ready=1 → ram_addr 0x010,0x011,0x012,0x013 on consecutive cycles; out_data equals RAM contents at those addresses on 4 consecutive cycles; out_last only on the 4th; busy falls 1 cycle after last pop.
- Same burst with out_ready=0 → exactly 2 ram_en pulses, then ram_en=0, out_valid=1 with out_data=mem[0x010] held stable. Raise out_ready → remaining beats are issued and delivered in order with no loss or duplication.
- req_addr=0x3FE, req_len=3 → addresses 0x3FE,0x3FF,0x000,0x001.
- Back-to-back requests (len 0 at 0x005, then len 1 at 0x100) with out_ready=1 → beats mem[0x005](last), mem[0x100], mem[0x101](last), in order.
- Random out_ready toggling over a len=7 burst → 8 beats in address order, each beat stable while stalled, FIFO never overflows (assertion).
- Assert rst_n=0 mid-burst after 2 issues, release, then issue req_addr=0x020, req_len=0 → only mem[0x020] appears, with out_last=1; no stale beats.

Source files
------------

// File: rtl/vrf_rd_seq_if.sv
// Request, RAM-port and output-stream signals of the VRF read sequencer.
// The sequencer uses the slave modport; the surrounding environment uses the master modport.
interface vrf_rd_seq_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;

  modport slave (
    input  req_valid, req_addr, req_len, ram_dout, out_ready,
    output req_ready, ram_en, ram_addr, out_valid, out_data, out_last, busy
  );

  modport master (
    output req_valid, req_addr, req_len, ram_dout, out_ready,
    input  req_ready, ram_en, ram_addr, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/vrf_rd_seq.sv
// Burst read sequencer for one VRF RAM port.
// It absorbs the 1-cycle read latency and streams the words through a 2-entry credit FIFO.
module vrf_rd_seq #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  vrf_rd_seq_if.slave   bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic [1:0]            fifo_last_q, fifo_last_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;

  logic       pop;
  logic       push;
  logic       accept;
  logic       issue;
  logic [2:0] occupancy;

  // Credit includes this cycle's pop, which keeps 1 beat/cycle with out_ready held high.
  always_comb begin
    pop       = (count_q != 2'd0) & bus.out_ready;
    push      = inflight_q;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    accept    = (state_q == IDLE) & bus.req_valid;
    issue     = (state_q == BUSY) & (occupancy < 3'd2);
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.ram_en    = issue;
  assign bus.ram_addr  = base_q + ADDR_WIDTH'(idx_q);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = fifo_data_q[rd_ptr_q];
  assign bus.out_last  = fifo_last_q[rd_ptr_q];
  assign bus.busy      = (state_q == BUSY) | inflight_q | (count_q != 2'd0);

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    idx_d           = idx_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue & (remaining_q == '0);
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q + {1'b0, push} - {1'b0, pop};

    if (accept) begin
      base_d      = bus.req_addr;
      remaining_d = bus.req_len;
      idx_d       = '0;
      state_d     = BUSY;
    end

    if (issue) begin
      idx_d       = idx_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
      if (remaining_q == '0) begin
        state_d = IDLE;
      end
    end

    if (push) begin
      fifo_data_d[wr_ptr_q] = bus.ram_dout;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      base_q          <= '0;
      idx_q           <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_last_q     <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      idx_q           <= idx_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_last_q     <= fifo_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
    end
  end

  // Payload storage needs no reset; it is only observed once count is non-zero.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
  end
endmodule

// File: tb/tb_vrf_rd_seq.sv
// Directed bench for vrf_rd_seq with a registered-read RAM model.
// An edge monitor logs issued addresses and popped beats, and these logs are checked against hand-derived bursts.
module tb_vrf_rd_seq;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vrf_rd_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  vrf_rd_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int ready_mode   = 0;
  int accept_cyc   = 0;
  int idle_cyc     = 0;

  logic [DW-1:0] mem [1<<AW];
  logic          en_s;
  logic [AW-1:0] addr_s;

  logic [AW-1:0] iss_addr [$];
  int            iss_cyc  [$];
  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  int            got_cyc  [$];
  int            issued_n;
  int            popped_n;
  bit            unstable;
  bit            overflow;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {8'hD0, 4'h0, a, a ^ 10'h155, 22'h0, a};
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = word_of(AW'(i));
  end

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: request captured mid-cycle, data registered at the next rising edge.
  always @(negedge clk) begin
    en_s   <= bus.ram_en;
    addr_s <= bus.ram_addr;
  end

  always @(posedge clk) begin
    if (en_s) bus.ram_dout <= mem[addr_s];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_en) begin
        iss_addr.push_back(bus.ram_addr);
        iss_cyc.push_back(cyc);
        issued_n++;
      end
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
        unstable = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        got_cyc.push_back(cyc);
        popped_n++;
      end
      if (issued_n - popped_n > 2) overflow = 1'b1;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic clear_log();
    iss_addr.delete();
    iss_cyc.delete();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    issued_n   = 0;
    popped_n   = 0;
    unstable   = 1'b0;
    overflow   = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput("req_ready_wait", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = len;
    accept_cyc    = cyc;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = ~addr;
    bus.req_len   = ~len;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      tick();
      n++;
    end
    idle_cyc = cyc;
    checkOutput("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic check_burst(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] ea;
    checkOutput("issue_count", 64'(iss_addr.size()), 64'(len + 1));
    checkOutput("beat_count", 64'(got_data.size()), 64'(len + 1));
    for (int k = 0; k <= len; k++) begin
      ea = base + AW'(k);
      if (k < iss_addr.size()) checkOutput($sformatf("addr%0d", k), 64'(iss_addr[k]), 64'(ea));
      if (k < got_data.size()) begin
        checkOutput($sformatf("data%0d", k), got_data[k], mem[ea]);
        checkOutput($sformatf("last%0d", k), 64'(got_last[k]), 64'(k == len));
      end
    end
    checkOutput("stable_while_stalled", 64'(unstable), 64'd0);
    checkOutput("no_overflow", 64'(overflow), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b0;
    clear_log();
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_ram_en", 64'(bus.ram_en), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_last", 64'(bus.out_last), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    $display("[TB] burst 0x010 len 3, consumer always ready");
    ready_mode = 1;
    clear_log();
    applyStimulus(10'h010, 3'd3);
    wait_idle(40);
    check_burst(10'h010, 3);
    if (iss_cyc.size() == 4 && got_cyc.size() == 4) begin
      checkOutput("first_issue_latency", 64'(iss_cyc[0] - accept_cyc), 64'd1);
      checkOutput("first_beat_latency", 64'(got_cyc[0] - accept_cyc), 64'd3);
      checkOutput("issue_back_to_back", 64'(iss_cyc[3] - iss_cyc[0]), 64'd3);
      checkOutput("beat_back_to_back", 64'(got_cyc[3] - got_cyc[0]), 64'd3);
      checkOutput("busy_fall", 64'(idle_cyc - got_cyc[3]), 64'd1);
    end

    $display("[TB] burst 0x010 len 3 with consumer stalled");
    ready_mode = 0;
    bus.out_ready = 1'b0;
    clear_log();
    applyStimulus(10'h010, 3'd3);
    bus.req_valid = 1'b1;
    bus.req_addr  = 10'h2AA;
    bus.req_len   = 3'd0;
    repeat (6) tick();
    checkOutput("req_ready_while_busy", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 1'b0;
    checkOutput("stall_issue_count", 64'(iss_addr.size()), 64'd2);
    checkOutput("stall_ram_en", 64'(bus.ram_en), 64'd0);
    checkOutput("stall_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("stall_out_data", bus.out_data, word_of(10'h010));
    checkOutput("stall_out_last", 64'(bus.out_last), 64'd0);
    ready_mode = 1;
    tick();
    wait_idle(40);
    check_burst(10'h010, 3);

    $display("[TB] address wrap at top of RAM");
    clear_log();
    applyStimulus(10'h3FE, 3'd3);
    wait_idle(40);
    check_burst(10'h3FE, 3);

    $display("[TB] back-to-back requests");
    clear_log();
    applyStimulus(10'h005, 3'd0);
    applyStimulus(10'h100, 3'd1);
    wait_idle(40);
    checkOutput("b2b_beat_count", 64'(got_data.size()), 64'd3);
    if (got_data.size() == 3) begin
      checkOutput("b2b_data0", got_data[0], word_of(10'h005));
      checkOutput("b2b_last0", 64'(got_last[0]), 64'd1);
      checkOutput("b2b_data1", got_data[1], word_of(10'h100));
      checkOutput("b2b_last1", 64'(got_last[1]), 64'd0);
      checkOutput("b2b_data2", got_data[2], word_of(10'h101));
      checkOutput("b2b_last2", 64'(got_last[2]), 64'd1);
    end

    $display("[TB] len 7 burst with random backpressure");
    ready_mode = 2;
    clear_log();
    applyStimulus(10'h0C0, 3'd7);
    wait_idle(300);
    check_burst(10'h0C0, 7);

    $display("[TB] reset in the middle of a burst");
    ready_mode = 1;
    clear_log();
    applyStimulus(10'h040, 3'd7);
    n = 0;
    while (issued_n < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_reset_issues_seen", 64'(issued_n >= 2), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ram_en", 64'(bus.ram_en), 64'd0);
    checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
    clear_log();
    #1 rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(10'h020, 3'd0);
    wait_idle(40);
    check_burst(10'h020, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
